packet_wrr_scheduler: RTL and testbench

PACKET_WRR_SCHEDULER -- requirements
Module: packet_wrr_scheduler

---
 rtl/packet_wrr_scheduler.sv | 124 ++++++++++++
 tb/tb_packet_wrr_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/packet_wrr_scheduler.sv
// Weighted round-robin packet scheduler for four requesters.
// Holds a grant per packet until fin or timeout, then gaps one cycle.
module packet_wrr_scheduler #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [N_REQ-1:0]   i_req,
  input  logic [N_REQ-1:0]   i_fin,
  input  logic               i_ready,
  input  logic [2*N_REQ-1:0] i_weight,
  output logic [N_REQ-1:0]   o_grant,
  output logic [1:0]         o_owner,
  output logic               o_busy,
  output logic               o_abort
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_t           r_state;
  state_t           w_next;
  logic [1:0]       r_owner;
  logic [2:0]       r_credit;
  logic [7:0]       r_cnt;
  logic [N_REQ-1:0] r_grant;
  logic             r_abort;

  logic             w_fin_own;
  logic             w_tmo;
  logic             w_keep;
  logic             w_found;
  logic [1:0]       w_idx;
  logic [1:0]       w_srch;
  logic [1:0]       w_win;
  logic             w_go;
  logic             w_rel_fin;
  logic             w_rel_tmo;
  logic [2:0]       w_load;
  logic [2:0]       w_dec;

  assign w_fin_own = i_fin[r_owner];
  assign w_tmo     = (r_cnt == CNT_MAX);
  assign w_keep    = (r_credit != 3'd0) && i_req[r_owner];

  // Rotating search starts just past the current owner.
  always_comb begin
    w_found = 1'b0;
    w_srch  = r_owner;
    w_idx   = r_owner;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_owner + 2'(k);
      if (!w_found && i_req[w_idx]) begin
        w_found = 1'b1;
        w_srch  = w_idx;
      end
    end
  end

  assign w_win  = w_keep ? r_owner : w_srch;
  assign w_load = {1'b0, i_weight[{w_win, 1'b0} +: 2]} + 3'd1;
  assign w_dec  = (r_credit != 3'd0) ? r_credit - 3'd1 : 3'd0;

  assign w_go      = (r_state == S_IDLE) && i_ready && (|i_req);
  assign w_rel_fin = (r_state == S_BUSY) && w_fin_own;
  assign w_rel_tmo = (r_state == S_BUSY) && !w_fin_own && w_tmo;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: if (w_go) w_next = S_BUSY;
      S_BUSY: if (w_rel_fin || w_rel_tmo) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_owner  <= 2'd3;
      r_credit <= 3'd0;
      r_cnt    <= 8'd0;
      r_grant  <= '0;
      r_abort  <= 1'b0;
    end else begin
      r_abort <= w_rel_tmo;
      if (w_go) begin
        r_owner <= w_win;
        r_cnt   <= 8'd0;
        r_grant <= N_REQ'(1) << w_win;
        if (!w_keep) r_credit <= w_load;
      end else if (r_state == S_BUSY) begin
        r_cnt <= r_cnt + 8'd1;
        if (w_rel_fin) begin
          r_grant  <= '0;
          r_credit <= w_dec;
        end else if (w_rel_tmo) begin
          r_grant  <= '0;
          r_credit <= 3'd0;
        end
      end
    end
  end

  always_comb begin
    o_grant = r_grant;
    o_busy  = |r_grant;
    o_owner = r_owner;
    o_abort = r_abort;
  end

endmodule

// File: tb/tb_packet_wrr_scheduler.sv
// Scoreboard bench for packet_wrr_scheduler: each expected grant episode
// is queued by the stimulus and checked by a monitor when it ends.
module tb_packet_wrr_scheduler;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] req = '0;
  logic [3:0] fin;
  logic       ready = 1'b0;
  logic [7:0] weight = '0;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic       abort;

  logic [3:0] fin_resp = '0;
  logic [3:0] fin_noise = '0;
  int         fin_delay = -1;
  int         gcyc = 0;

  typedef struct {
    logic [3:0] g;
    int         len;
    logic       ab;
  } ep_t;

  ep_t q[$];
  int  n_chk = 0;
  int  n_fail = 0;
  int  n_starts = 0;
  logic [3:0] prev = '0;
  int  cur_len = 0;

  assign fin = fin_resp | fin_noise;

  packet_wrr_scheduler dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req(req),
    .i_fin(fin),
    .i_ready(ready),
    .i_weight(weight),
    .o_grant(grant),
    .o_owner(owner),
    .o_busy(busy),
    .o_abort(abort)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n || grant == 4'b0) begin
      gcyc = 0;
      fin_resp = '0;
    end else begin
      gcyc++;
      fin_resp = (gcyc == fin_delay) ? grant : 4'b0;
    end
  end

  always @(negedge clk) begin
    ep_t e;
    if (!rst_n) begin
      prev = '0;
      cur_len = 0;
    end else begin
      chk("busy_eq_or_grant", int'(busy), int'(|grant));
      chk("grant_onehot", int'($countones(grant) <= 1), 1);
      if (prev != 4'b0 && grant == 4'b0) begin
        if (q.size() == 0) begin
          chk("unexpected_grant", int'(prev), 0);
        end else begin
          e = q.pop_front();
          chk("grant_vec", int'(prev), int'(e.g));
          if (e.len > 0) chk("grant_len", cur_len, e.len);
          chk("abort_at_end", int'(abort), int'(e.ab));
        end
      end else begin
        chk("abort_quiet", int'(abort), 0);
      end
      if (grant != 4'b0) begin
        if (prev == 4'b0) begin
          n_starts++;
          cur_len = 1;
        end else begin
          cur_len++;
          chk("grant_stable", int'(grant), int'(prev));
        end
      end
      prev = grant;
    end
  end

  task automatic push(input logic [3:0] g, input int len, input logic ab);
    ep_t e;
    e.g = g;
    e.len = len;
    e.ab = ab;
    q.push_back(e);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic wait_starts(input int target, input string nm);
    int t = 0;
    while (n_starts < target && t < 300) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk(nm, n_starts, target);
  endtask

  task automatic wait_drain(input string nm);
    int t = 0;
    while ((q.size() != 0 || busy) && t < 300) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk(nm, q.size(), 0);
    repeat (3) @(negedge clk);
    #2;
  endtask

  initial begin
    int base;
    #1 rst_n = 1'b0;
    #3;
    chk("rst_grant", int'(grant), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_abort", int'(abort), 0);
    chk("rst_owner", int'(owner), 3);
    repeat (2) @(negedge clk);

    // Equal weights: plain rotation 0,1,2,3,0.
    weight = 8'h00;
    req = 4'b1111;
    ready = 1'b1;
    fin_delay = 5;
    push(4'b0001, 5, 0);
    push(4'b0010, 5, 0);
    push(4'b0100, 5, 0);
    push(4'b1000, 5, 0);
    push(4'b0001, 5, 0);
    base = n_starts;
    #2 rst_n = 1'b1;
    wait_starts(base + 5, "rr_starts");
    req = 4'b0;
    wait_drain("rr_drain");

    // Weighted: req0 gets three packets per turn.
    apply_reset();
    weight = 8'h02;
    req = 4'b0011;
    fin_delay = 3;
    for (int i = 0; i < 2; i++) begin
      push(4'b0001, 3, 0);
      push(4'b0001, 3, 0);
      push(4'b0001, 3, 0);
      push(4'b0010, 3, 0);
    end
    base = n_starts;
    wait_starts(base + 8, "wrr_starts");
    req = 4'b0;
    wait_drain("wrr_drain");

    // Timeout then fresh re-grant to the only requester.
    apply_reset();
    weight = 8'h00;
    req = 4'b0100;
    fin_delay = -1;
    push(4'b0100, 64, 1);
    push(4'b0100, 4, 0);
    base = n_starts;
    wait_starts(base + 1, "tmo_start");
    begin
      int t = 0;
      while (!abort && t < 200) begin
        @(negedge clk);
        #2;
        t++;
      end
    end
    chk("tmo_abort_seen", int'(abort), 1);
    fin_delay = 4;
    wait_starts(base + 2, "tmo_regrant");
    req = 4'b0;
    wait_drain("tmo_drain");

    // ready gates only new grants.
    apply_reset();
    ready = 1'b0;
    req = 4'b1000;
    fin_delay = 8;
    push(4'b1000, 8, 0);
    repeat (10) @(negedge clk);
    #2;
    chk("rdy_blocked", int'(grant), 0);
    ready = 1'b1;
    @(negedge clk);
    #2;
    chk("rdy_latency", int'(grant), 4'b1000);
    ready = 1'b0;
    req = 4'b0;
    wait_drain("rdy_drain");
    ready = 1'b1;

    // fin wins on the timeout cycle; non-owner fin ignored.
    apply_reset();
    fin_noise = 4'b0100;
    req = 4'b0010;
    fin_delay = 64;
    push(4'b0010, 64, 0);
    base = n_starts;
    wait_starts(base + 1, "race_start");
    req = 4'b0;
    wait_drain("race_drain");
    fin_noise = 4'b0;

    // Reset mid-packet drops grant asynchronously.
    apply_reset();
    req = 4'b0010;
    fin_delay = -1;
    base = n_starts;
    wait_starts(base + 1, "mid_start");
    repeat (3) @(negedge clk);
    #2;
    chk("mid_grant", int'(grant), 4'b0010);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_grant", int'(grant), 0);
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_abort", int'(abort), 0);
    repeat (2) @(negedge clk);
    req = 4'b1111;
    fin_delay = 3;
    push(4'b0001, 3, 0);
    base = n_starts;
    #2 rst_n = 1'b1;
    wait_starts(base + 1, "post_rst_start");
    req = 4'b0;
    wait_drain("post_rst_drain");

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
